qoi_encoder: RTL and testbench

Streaming QOI chunk encoder: the transmit-side counterpart of `qoi_decoder`. It accepts one RGBA pixel per handshake and emits QOI chunks of 1 to 5 bytes. The output uses the same byte-vector layout the decoder consumes, so the two blocks can be chained for loopback. It maintains the QOI running state for one image at a time: previous pixel, 64-entry colour index, and run length.

---
 rtl/qoi_encoder_if.sv | 31 +++
 rtl/qoi_encoder.sv | 196 +++++++++++++++++++
 tb/tb_qoi_encoder.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qoi_encoder_if.sv
`default_nettype none
// ============================================================================
// qoi_encoder_if : pixel-in / chunk-out handshake bundle for qoi_encoder
// Revision 1.0
// ============================================================================
interface qoi_encoder_if;
  logic            px_valid;
  logic            px_ready;
  logic            px_last;
  logic [7:0]      r;
  logic [7:0]      g;
  logic [7:0]      b;
  logic [7:0]      a;
  logic [4:0][7:0] chunk;
  logic [2:0]      chunk_len;
  logic            chunk_valid;
  logic            chunk_ready;

  // Pixel producer / chunk consumer side
  modport master (
    output px_valid, px_last, r, g, b, a, chunk_ready,
    input  px_ready, chunk, chunk_len, chunk_valid
  );

  // Encoder side
  modport slave (
    input  px_valid, px_last, r, g, b, a, chunk_ready,
    output px_ready, chunk, chunk_len, chunk_valid
  );
endinterface
`default_nettype wire

// File: rtl/qoi_encoder.sv
`default_nettype none
// ============================================================================
// qoi_encoder : streaming QOI chunk encoder, one RGBA pixel in, 1-5 bytes out
// Revision 1.0
// ============================================================================
module qoi_encoder (
  input  wire logic     clk,
  input  wire logic     rst,
  qoi_encoder_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  // Pixels are packed as {r, g, b, a}
  localparam logic [31:0] PREV_INIT = 32'h0000_00FF;
  localparam logic [5:0]  RUN_MAX   = 6'd62;

  state_t       state_q, state_d;
  logic [5:0]   run_q, run_d;
  logic [31:0]  prev_q, prev_d;
  logic [63:0]  idx_vld_q, idx_vld_d;
  logic [31:0]  index_q [64];
  logic [39:0]  chunk_q, chunk_d;
  logic [2:0]   len_q, len_d;
  logic         valid_q, valid_d;
  logic [39:0]  pend_chunk_q, pend_chunk_d;
  logic [2:0]   pend_len_q, pend_len_d;

  logic [31:0]  pix;
  logic         out_free;
  logic         accept;
  logic         idx_we;
  logic [5:0]   hash;
  logic [31:0]  idx_entry;
  logic [7:0]   dr, dg, db;
  logic [7:0]   dr_dg, db_dg;
  logic [7:0]   dr_b, dg_b, db_b;
  logic [7:0]   dg_l, rg_l, bg_l;
  logic [39:0]  px_chunk;
  logic [2:0]   px_len;
  logic [5:0]   run_inc;

  assign pix          = {bus.r, bus.g, bus.b, bus.a};
  assign out_free     = !valid_q || bus.chunk_ready;
  assign bus.px_ready = (state_q == S_IDLE) && out_free;
  assign accept       = bus.px_valid && bus.px_ready;
  assign run_inc      = run_q + 6'd1;

  assign bus.chunk       = chunk_q;
  assign bus.chunk_len   = len_q;
  assign bus.chunk_valid = valid_q;

  // Pixel chunk selection; only used when the pixel differs from prev
  always_comb begin
    hash      = bus.r[5:0] * 6'd3 + bus.g[5:0] * 6'd5
              + bus.b[5:0] * 6'd7 + bus.a[5:0] * 6'd11;
    idx_entry = idx_vld_q[hash] ? index_q[hash] : 32'd0;

    dr    = bus.r - prev_q[31:24];
    dg    = bus.g - prev_q[23:16];
    db    = bus.b - prev_q[15:8];
    dr_dg = dr - dg;
    db_dg = db - dg;

    // Biased differences turn signed range tests into unsigned compares
    dr_b  = dr + 8'd2;
    dg_b  = dg + 8'd2;
    db_b  = db + 8'd2;
    dg_l  = dg + 8'd32;
    rg_l  = dr_dg + 8'd8;
    bg_l  = db_dg + 8'd8;

    px_chunk = '0;
    px_len   = 3'd0;
    if (idx_entry == pix) begin
      px_chunk[7:0] = {2'b00, hash};
      px_len        = 3'd1;
    end else if (bus.a == prev_q[7:0]) begin
      if (dr_b < 8'd4 && dg_b < 8'd4 && db_b < 8'd4) begin
        px_chunk[7:0] = {2'b01, dr_b[1:0], dg_b[1:0], db_b[1:0]};
        px_len        = 3'd1;
      end else if (dg_l < 8'd64 && rg_l < 8'd16 && bg_l < 8'd16) begin
        px_chunk[15:0] = {rg_l[3:0], bg_l[3:0], 2'b10, dg_l[5:0]};
        px_len         = 3'd2;
      end else begin
        px_chunk[31:0] = {bus.b, bus.g, bus.r, 8'hFE};
        px_len         = 3'd4;
      end
    end else begin
      px_chunk = {bus.a, bus.b, bus.g, bus.r, 8'hFF};
      px_len   = 3'd5;
    end
  end

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    prev_d       = prev_q;
    idx_vld_d    = idx_vld_q;
    idx_we       = 1'b0;
    chunk_d      = chunk_q;
    len_d        = len_q;
    valid_d      = valid_q;
    pend_chunk_d = pend_chunk_q;
    pend_len_d   = pend_len_q;

    // Output slot is empty or being drained; refilled below if a chunk is ready
    if (out_free) begin
      valid_d = 1'b0;
      chunk_d = '0;
      len_d   = 3'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_we          = 1'b1;
          idx_vld_d[hash] = 1'b1;
          prev_d          = pix;
          if (pix == prev_q) begin
            if (run_inc == RUN_MAX || bus.px_last) begin
              chunk_d = {32'd0, 2'b11, run_q};
              len_d   = 3'd1;
              valid_d = 1'b1;
              run_d   = 6'd0;
            end else begin
              run_d = run_inc;
            end
          end else if (run_q != 6'd0) begin
            chunk_d      = {32'd0, 2'b11, run_q - 6'd1};
            len_d        = 3'd1;
            valid_d      = 1'b1;
            pend_chunk_d = px_chunk;
            pend_len_d   = px_len;
            run_d        = 6'd0;
            state_d      = S_PEND;
          end else begin
            chunk_d = px_chunk;
            len_d   = px_len;
            valid_d = 1'b1;
          end
          if (bus.px_last) begin
            prev_d    = PREV_INIT;
            run_d     = 6'd0;
            idx_vld_d = '0;
          end
        end
      end
      S_PEND: begin
        if (bus.chunk_ready) begin
          chunk_d = pend_chunk_q;
          len_d   = pend_len_q;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      run_q        <= 6'd0;
      prev_q       <= PREV_INIT;
      idx_vld_q    <= '0;
      chunk_q      <= '0;
      len_q        <= 3'd0;
      valid_q      <= 1'b0;
      pend_chunk_q <= '0;
      pend_len_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      prev_q       <= prev_d;
      idx_vld_q    <= idx_vld_d;
      chunk_q      <= chunk_d;
      len_q        <= len_d;
      valid_q      <= valid_d;
      pend_chunk_q <= pend_chunk_d;
      pend_len_q   <= pend_len_d;
    end
  end

  // Entry contents need no reset: the valid vector masks stale data
  always_ff @(posedge clk) begin
    if (idx_we) begin
      index_q[hash] <= pix;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qoi_encoder.sv
`default_nettype none
// ============================================================================
// tb_qoi_encoder : directed and randomized checks of qoi_encoder
// Revision 1.0
// ============================================================================
module tb_qoi_encoder;

  typedef logic [42:0] chk_t;  // {len, b4, b3, b2, b1, b0}

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   rand_ready = 1'b0;

  chk_t obs_q[$];
  chk_t exp_q[$];

  logic [31:0] m_prev;
  int          m_run;
  logic [31:0] m_index [64];

  qoi_encoder_if bus();

  qoi_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst && bus.chunk_valid && bus.chunk_ready)
      obs_q.push_back({bus.chunk_len, bus.chunk});

  always @(posedge clk)
    if (rand_ready) begin
      #1;
      bus.chunk_ready = ($urandom_range(0, 3) != 0);
    end

  function automatic chk_t mk(input int len, input int b0, input int b1 = 0,
                              input int b2 = 0, input int b3 = 0, input int b4 = 0);
    return {3'(len), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  function automatic int sd(input int x);
    int d;
    d = x & 255;
    return (d >= 128) ? d - 256 : d;
  endfunction

  function automatic void model_init();
    m_prev = {8'd0, 8'd0, 8'd0, 8'd255};
    m_run  = 0;
    for (int i = 0; i < 64; i++) m_index[i] = 32'd0;
  endfunction

  // Reference QOI step straight from the chunk rules
  function automatic void model_px(input logic [31:0] p, input bit last);
    int r, g, b, a, pr, pg, pb, pa, h, dr, dg, db, rg, bg;
    r = p[31:24]; g = p[23:16]; b = p[15:8]; a = p[7:0];
    pr = m_prev[31:24]; pg = m_prev[23:16]; pb = m_prev[15:8]; pa = m_prev[7:0];
    h = (3 * r + 5 * g + 7 * b + 11 * a) % 64;
    if (p == m_prev) begin
      m_run++;
      if (m_run == 62 || last) begin
        exp_q.push_back(mk(1, 192 + m_run - 1));
        m_run = 0;
      end
    end else begin
      if (m_run > 0) begin
        exp_q.push_back(mk(1, 192 + m_run - 1));
        m_run = 0;
      end
      if (m_index[h] == p) exp_q.push_back(mk(1, h));
      else if (a == pa) begin
        dr = sd(r - pr); dg = sd(g - pg); db = sd(b - pb);
        rg = sd(dr - dg); bg = sd(db - dg);
        if (dr >= -2 && dr <= 1 && dg >= -2 && dg <= 1 && db >= -2 && db <= 1)
          exp_q.push_back(mk(1, 64 + (dr + 2) * 16 + (dg + 2) * 4 + (db + 2)));
        else if (dg >= -32 && dg <= 31 && rg >= -8 && rg <= 7 && bg >= -8 && bg <= 7)
          exp_q.push_back(mk(2, 128 + dg + 32, (rg + 8) * 16 + (bg + 8)));
        else
          exp_q.push_back(mk(4, 254, r, g, b));
      end else
        exp_q.push_back(mk(5, 255, r, g, b, a));
    end
    m_index[h] = p;
    m_prev = p;
    if (last) model_init();
  endfunction

  task automatic px_idle();
    bus.px_valid = 1'b0;
    bus.px_last  = 1'b0;
  endtask

  task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [7:0] a, input bit last);
    int n = 0;
    bus.px_valid = 1'b1;
    bus.px_last = last;
    bus.r = r; bus.g = g; bus.b = b; bus.a = a;
    forever begin
      @(negedge clk);
      if (bus.px_ready) begin
        @(posedge clk);
        #1;
        model_px({r, g, b, a}, last);
        break;
      end
      n++;
      if (n > 300) begin
        checks++; failures++;
        $display("FAIL send_px timeout px_ready never high, pixel=%02h%02h%02h%02h", r, g, b, a);
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    px_idle();
    rand_ready = 1'b0;
    bus.chunk_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_init();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (obs_q.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    px_idle();
    bus.chunk_ready = 1'b1;
    bus.r = 8'd0; bus.g = 8'd0; bus.b = 8'd0; bus.a = 8'd0;
    #1;
    checks++; if (bus.chunk_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.chunk_valid); end
    checks++; if (bus.chunk_len !== 3'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", bus.chunk_len); end
    checks++; if (bus.chunk !== 40'd0) begin failures++; $display("FAIL reset_chunk got=%h exp=0", bus.chunk); end
    do_reset();
    @(negedge clk);
    checks++; if (bus.px_ready !== 1'b1) begin failures++; $display("FAIL reset_px_ready got=%b exp=1", bus.px_ready); end
  endtask

  task automatic test_run_break();
    chk_t exp[$];
    do_reset();
    repeat (3) send_px(8'd0, 8'd0, 8'd0, 8'd255, 1'b0);
    send_px(8'd10, 8'd0, 8'd0, 8'd255, 1'b0);
    px_idle();
    exp = '{mk(1, 'hC2), mk(4, 'hFE, 'h0A, 0, 0)};
    drain(exp.size());
    checks++; if (obs_q.size() != exp.size()) begin failures++; $display("FAIL run_break_count got=%0d exp=%0d", obs_q.size(), exp.size()); end
    foreach (exp[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp[i]) begin
        failures++; $display("FAIL run_break_chunk%0d got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp[i]);
      end
    end
  endtask

  task automatic test_index_diff();
    chk_t exp[$];
    do_reset();
    send_px(8'd1, 8'd2, 8'd3, 8'd255, 1'b0);
    send_px(8'd0, 8'd1, 8'd2, 8'd255, 1'b0);
    send_px(8'd1, 8'd2, 8'd3, 8'd255, 1'b0);
    px_idle();
    exp = '{mk(2, 'hA2, 'h79), mk(1, 'h55), mk(1, 'h17)};
    drain(exp.size());
    checks++; if (obs_q.size() != exp.size()) begin failures++; $display("FAIL luma_diff_index_count got=%0d exp=%0d", obs_q.size(), exp.size()); end
    foreach (exp[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp[i]) begin
        failures++; $display("FAIL luma_diff_index_chunk%0d got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp[i]);
      end
    end
  endtask

  task automatic test_rgba_index0();
    do_reset();
    send_px(8'd0, 8'd0, 8'd0, 8'd128, 1'b0);
    px_idle();
    checks++; if (bus.chunk_valid !== 1'b1 || bus.chunk_len !== 3'd5) begin failures++; $display("FAIL rgba_latency valid=%b len=%0d exp valid=1 len=5", bus.chunk_valid, bus.chunk_len); end
    drain(1);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== mk(5, 'hFF, 0, 0, 0, 'h80)) begin failures++; $display("FAIL rgba_chunk n=%0d got=%h exp=%h", obs_q.size(), obs_q[0], mk(5, 'hFF, 0, 0, 0, 'h80)); end
    do_reset();
    send_px(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    px_idle();
    drain(1);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== mk(1, 'h00)) begin failures++; $display("FAIL index0_chunk n=%0d got=%h exp=%h", obs_q.size(), obs_q[0], mk(1, 'h00)); end
  endtask

  task automatic test_run_limit();
    chk_t exp[$];
    do_reset();
    for (int i = 0; i < 64; i++) send_px(8'd0, 8'd0, 8'd0, 8'd255, i == 63);
    send_px(8'd0, 8'd0, 8'd0, 8'd255, 1'b1);
    px_idle();
    exp = '{mk(1, 'hFD), mk(1, 'hC1), mk(1, 'hC0)};
    drain(exp.size());
    checks++; if (obs_q.size() != exp.size()) begin failures++; $display("FAIL run_limit_count got=%0d exp=%0d", obs_q.size(), exp.size()); end
    foreach (exp[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp[i]) begin
        failures++; $display("FAIL run_limit_chunk%0d got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    chk_t exp[$];
    do_reset();
    repeat (2) send_px(8'd0, 8'd0, 8'd0, 8'd255, 1'b0);
    bus.chunk_ready = 1'b0;
    send_px(8'd5, 8'd5, 8'd5, 8'd255, 1'b0);
    bus.px_valid = 1'b1;
    bus.r = 8'd6; bus.g = 8'd5; bus.b = 8'd5; bus.a = 8'd255;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.chunk_valid !== 1'b1 || {bus.chunk_len, bus.chunk} !== mk(1, 'hC1) || bus.px_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cycle%0d valid=%b chunk=%h px_ready=%b exp valid=1 chunk=%h px_ready=0",
                 i, bus.chunk_valid, {bus.chunk_len, bus.chunk}, bus.px_ready, mk(1, 'hC1));
      end
    end
    @(posedge clk);
    #1;
    bus.chunk_ready = 1'b1;
    send_px(8'd6, 8'd5, 8'd5, 8'd255, 1'b0);
    px_idle();
    exp = '{mk(1, 'hC1), mk(2, 'hA5, 'h88), mk(1, 'h7A)};
    drain(exp.size());
    checks++; if (obs_q.size() != exp.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", obs_q.size(), exp.size()); end
    foreach (exp[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp[i]) begin
        failures++; $display("FAIL stall_chunk%0d got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp[i]);
      end
    end
  endtask

  task automatic test_reset_pend();
    do_reset();
    bus.chunk_ready = 1'b0;
    send_px(8'd0, 8'd0, 8'd0, 8'd255, 1'b0);
    send_px(8'd1, 8'd1, 8'd1, 8'd255, 1'b0);
    px_idle();
    @(negedge clk);
    checks++; if (bus.chunk_valid !== 1'b1 || bus.px_ready !== 1'b0) begin failures++; $display("FAIL pend_entry valid=%b px_ready=%b exp valid=1 px_ready=0", bus.chunk_valid, bus.px_ready); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.chunk_valid !== 1'b0) begin failures++; $display("FAIL pend_async_reset valid=%b exp=0", bus.chunk_valid); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_init();
    obs_q.delete();
    exp_q.delete();
    bus.chunk_ready = 1'b1;
    send_px(8'd1, 8'd2, 8'd3, 8'd255, 1'b0);
    px_idle();
    drain(1);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== mk(2, 'hA2, 'h79)) begin failures++; $display("FAIL pend_after_reset n=%0d got=%h exp=%h", obs_q.size(), obs_q[0], mk(2, 'hA2, 'h79)); end
  endtask

  task automatic test_random();
    logic [7:0] pal [4][4];
    logic [7:0] cr, cg, cb, ca;
    int sel, k;
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) pal[i][j] = 8'($urandom_range(0, 255));
    cr = 8'd0; cg = 8'd0; cb = 8'd0; ca = 8'd255;
    rand_ready = 1'b1;
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 35) begin
        // repeat previous pixel
      end else if (sel < 55) begin
        k = $urandom_range(0, 3);
        cr = pal[k][0]; cg = pal[k][1]; cb = pal[k][2]; ca = pal[k][3];
      end else if (sel < 75) begin
        cr = cr + 8'($urandom_range(0, 3)) - 8'd2;
        cg = cg + 8'($urandom_range(0, 3)) - 8'd2;
        cb = cb + 8'($urandom_range(0, 3)) - 8'd2;
      end else if (sel < 90) begin
        k = $urandom_range(0, 70);
        cg = cg + 8'(k) - 8'd35;
        cr = cr + 8'(k) - 8'd35 + 8'($urandom_range(0, 18)) - 8'd9;
        cb = cb + 8'(k) - 8'd35 + 8'($urandom_range(0, 18)) - 8'd9;
      end else begin
        cr = 8'($urandom_range(0, 255)); cg = 8'($urandom_range(0, 255));
        cb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) ca = 8'($urandom_range(0, 255));
      end
      send_px(cr, cg, cb, ca, $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) begin
        px_idle();
        @(posedge clk);
        #1;
      end
    end
    px_idle();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    bus.chunk_ready = 1'b1;
    drain(exp_q.size());
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL random_chunk%0d got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_break();
    test_index_diff();
    test_rgba_index0();
    test_run_limit();
    test_backpressure();
    test_reset_pend();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
